// File: rtl/mem_arb_bridge_if.sv
// mem_arb_bridge_if
//   Bundles every signal between the bridge, the core and the shared memory
//   port. The bridge connects through the "master" modport. The core and the
//   memory model connect through the "slave" modport.
//
//   Handshake semantics, in one place:
//   * Core side. inst_req/data_req are level requests. The core holds a
//     request and its attributes until x_stall drops. The matching x_rdata is
//     valid in the first cycle where x_stall is 0. When both stalls are 0 in
//     a cycle, the pipeline advances, and the bridge forgets both completions
//     at that edge.
//   * Memory side. mem_req is the request valid. mem_addr_ok is its ready.
//     The request is accepted on the edge where both are 1. While mem_req is
//     1, mem_wr/mem_sel/mem_addr/mem_wdata hold steady. mem_data_ok is a
//     one-cycle response strobe, and mem_rdata is valid with it. At most one
//     transaction is outstanding.
//
//   Port summary (the bridge's view through "master"):
//     in : inst_req, inst_addr, data_req, data_wr, data_sel, data_addr,
//          data_wdata, flush, mem_addr_ok, mem_data_ok, mem_rdata
//     out: inst_rdata, inst_stall, data_rdata, data_stall, stall_cnt,
//          mem_req, mem_wr, mem_sel, mem_addr, mem_wdata
interface mem_arb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // core fetch side
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_stall;

  // core data side
  logic              data_req;
  logic              data_wr;
  logic [SEL_W-1:0]  data_sel;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_stall;
  logic              flush;
  logic [31:0]       stall_cnt;

  // shared memory port
  logic              mem_req;
  logic              mem_wr;
  logic [SEL_W-1:0]  mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_rdata, inst_stall,
    input  data_req, data_wr, data_sel, data_addr, data_wdata, flush,
    output data_rdata, data_stall, stall_cnt,
    output mem_req, mem_wr, mem_sel, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_rdata, inst_stall,
    output data_req, data_wr, data_sel, data_addr, data_wdata, flush,
    input  data_rdata, data_stall, stall_cnt,
    input  mem_req, mem_wr, mem_sel, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_arb_bridge.sv
// mem_arb_bridge
//   Arbitrates a core's instruction-fetch and load/store requests onto one
//   shared memory port. Only one memory transaction is outstanding at a time.
//   The request attributes are latched when the transaction starts. Later
//   changes on the core inputs therefore cannot disturb a transaction that is
//   already in flight.
//
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous active-high reset
//     bus      mem_arb_bridge_if.master (core fetch/data side + memory port)
//     state_o  FSM state for observation: 0 IDLE, 1 ISSUE_I, 2 WAIT_I,
//              3 ISSUE_D, 4 WAIT_D
//
//   Parameters:
//     ADDR_W     address width
//     DATA_W     data width (a multiple of 8)
//     DATA_PRIO  1 = data wins simultaneous requests, 0 = fetch wins
module mem_arb_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DATA_PRIO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arb_bridge_if.master      bus,
  output logic [2:0]            state_o
);
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    WAIT_I  = 3'd2,
    ISSUE_D = 3'd3,
    WAIT_D  = 3'd4
  } state_t;

  state_t            state_q;
  logic              inst_done_q;
  logic              data_done_q;
  logic              discard_q;   // in-flight fetch was flushed; drop its data
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              req_q;
  logic              wr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       stall_cnt_q;

  logic inst_pend;
  logic data_pend;
  logic data_first;
  logic advance;
  logic fetch_busy;

  assign inst_pend  = bus.inst_req & ~inst_done_q;
  assign data_pend  = bus.data_req & ~data_done_q;
  assign data_first = data_pend & ((DATA_PRIO != 0) | ~inst_pend);
  // With neither stall high, the pipeline moves on and both completions are
  // consumed.
  assign advance    = ~inst_pend & ~data_pend;
  assign fetch_busy = (state_q == ISSUE_I) | (state_q == WAIT_I);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      discard_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      req_q        <= 1'b0;
      wr_q         <= 1'b0;
      sel_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (advance) begin
        inst_done_q <= 1'b0;
        data_done_q <= 1'b0;
      end
      if (bus.flush) begin
        inst_done_q <= 1'b0;
        if (fetch_busy) discard_q <= 1'b1;
      end
      if (!advance && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end

      // Later assignments in this case override the flush/advance updates
      // above for the same edge.
      case (state_q)
        IDLE: begin
          if (data_first) begin
            state_q <= ISSUE_D;
            req_q   <= 1'b1;
            wr_q    <= bus.data_wr;
            sel_q   <= bus.data_wr ? bus.data_sel : '1;
            addr_q  <= bus.data_addr;
            wdata_q <= bus.data_wdata;
          end else if (inst_pend) begin
            state_q <= ISSUE_I;
            req_q   <= 1'b1;
            wr_q    <= 1'b0;
            sel_q   <= '1;
            addr_q  <= bus.inst_addr;
            wdata_q <= '0;
          end
        end
        ISSUE_I: begin
          if (bus.mem_addr_ok) begin
            state_q <= WAIT_I;
            req_q   <= 1'b0;
          end
        end
        WAIT_I: begin
          if (bus.mem_data_ok) begin
            state_q <= IDLE;
            // A flush arriving with the response also discards it.
            if (discard_q || bus.flush) begin
              discard_q <= 1'b0;
            end else begin
              inst_done_q  <= 1'b1;
              inst_rdata_q <= bus.mem_rdata;
            end
          end
        end
        ISSUE_D: begin
          if (bus.mem_addr_ok) begin
            state_q <= WAIT_D;
            req_q   <= 1'b0;
          end
        end
        WAIT_D: begin
          if (bus.mem_data_ok) begin
            state_q     <= IDLE;
            data_done_q <= 1'b1;
            if (!wr_q) data_rdata_q <= bus.mem_rdata;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst_rdata = inst_rdata_q;
  assign bus.inst_stall = inst_pend;
  assign bus.data_rdata = data_rdata_q;
  assign bus.data_stall = data_pend;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_wr     = wr_q;
  assign bus.mem_sel    = sel_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_mem_arb_bridge.sv
// tb_mem_arb_bridge
//   Directed and lightly randomised checks of mem_arb_bridge. The bench acts
//   as both the core and the memory. Every memory request the bench provokes
//   is pushed to exp_q as {wr, sel, addr, wdata}. The entry is popped when
//   the bridge raises mem_req.
module tb_mem_arb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 1 + 4 + AW + DW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE_I = 3'd1;
  localparam logic [2:0] S_WAIT_I  = 3'd2;
  localparam logic [2:0] S_WAIT_D  = 3'd4;

  logic clk;
  logic rst;
  logic [2:0] state;

  mem_arb_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arb_bridge #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .state_o (state)
  );

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] rd_q[$];
  int checks;
  int failures;
  logic [DW-1:0] last_fetch;
  logic [DW-1:0] last_load;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_sel    = '0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
    bus.flush       = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  // Waits (bounded) for mem_req.
  task automatic wait_req(output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while (!bus.mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!bus.mem_req) timeout = 1'b1;
  endtask

  // Memory responder. Waits for mem_req and captures the request. It then
  // holds addr_ok low for addr_lat cycles, accepts, waits data_lat cycles,
  // and returns rdata. It ends one cycle after data_ok.
  task automatic mem_serve(input int addr_lat, input int data_lat,
                           input logic [DW-1:0] rdata,
                           output logic [EW-1:0] seen, output bit timeout);
    seen = '0;
    wait_req(timeout);
    if (timeout) return;
    seen = {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata};
    repeat (addr_lat) tick();
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.mem_addr_ok = 1'b0;
    repeat (data_lat) tick();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = rdata;
    tick();
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, S_IDLE); end
    checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    checks++; if (bus.inst_rdata !== '0 || bus.data_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.inst_rdata, bus.data_rdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_alone();
    logic [EW-1:0] e;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0000;
    exp_q.push_back({1'b0, 4'hF, 32'hBFC0_0000, 32'h0});
    rd_q.push_back(32'h2401_0001);
    #1;
    checks++; if (bus.inst_stall !== 1'b1 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_c0 got=stall%b/req%b exp=1/0", bus.inst_stall, bus.mem_req); end
    tick();
    checks++; if (bus.mem_req !== 1'b1 || state !== S_ISSUE_I) begin failures++; $display("FAIL fetch_issue got=req%b/st%0d exp=1/%0d", bus.mem_req, state, S_ISSUE_I); end
    e = exp_q.pop_front();
    checks++; if ({bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== e) begin failures++; $display("FAIL fetch_bus got=%h exp=%h", {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata}, e); end
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.mem_addr_ok = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || state !== S_WAIT_I) begin failures++; $display("FAIL fetch_wait got=req%b/st%0d exp=0/%0d", bus.mem_req, state, S_WAIT_I); end
    tick();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h2401_0001;
    checks++; if (bus.inst_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_at_dok got=%b exp=1", bus.inst_stall); end
    tick();
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
    last_fetch = rd_q.pop_front();
    checks++; if (bus.inst_stall !== 1'b0) begin failures++; $display("FAIL fetch_stall_drop got=%b exp=0", bus.inst_stall); end
    checks++; if (bus.inst_rdata !== last_fetch) begin failures++; $display("FAIL fetch_rdata got=%h exp=%h", bus.inst_rdata, last_fetch); end
    checks++; if (bus.stall_cnt !== 32'd4) begin failures++; $display("FAIL fetch_stall_cnt got=%0d exp=4", bus.stall_cnt); end
    bus.inst_req = 1'b0;
    tick();
    checks++; if (state !== S_IDLE || bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_idle got=st%0d/req%b exp=0/0", state, bus.mem_req); end
  endtask

  task automatic test_conflict();
    logic [EW-1:0] e;
    logic [EW-1:0] seen;
    bit to;
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'hBFC0_0010;
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b0;
    bus.data_sel   = 4'b0001;
    bus.data_addr  = 32'h8000_0010;
    bus.data_wdata = 32'h0;
    exp_q.push_back({1'b0, 4'hF, 32'h8000_0010, 32'h0});
    exp_q.push_back({1'b0, 4'hF, 32'hBFC0_0010, 32'h0});
    rd_q.push_back(32'h1111_1111);
    rd_q.push_back(32'h2222_2222);
    mem_serve(0, 1, 32'h1111_1111, seen, to);
    checks++; if (to) begin failures++; $display("FAIL conflict_load_timeout got=no_req exp=req"); end
    e = exp_q.pop_front();
    checks++; if (seen !== e) begin failures++; $display("FAIL conflict_first got=%h exp=%h", seen, e); end
    last_load = rd_q.pop_front();
    checks++; if (bus.data_stall !== 1'b0 || bus.inst_stall !== 1'b1) begin failures++; $display("FAIL conflict_mid_stalls got=d%b/i%b exp=0/1", bus.data_stall, bus.inst_stall); end
    checks++; if (bus.mem_req !== 1'b0 || state !== S_IDLE) begin failures++; $display("FAIL conflict_idle_gap got=req%b/st%0d exp=0/0", bus.mem_req, state); end
    checks++; if (bus.data_rdata !== last_load) begin failures++; $display("FAIL conflict_load_rdata got=%h exp=%h", bus.data_rdata, last_load); end
    mem_serve(1, 0, 32'h2222_2222, seen, to);
    checks++; if (to) begin failures++; $display("FAIL conflict_fetch_timeout got=no_req exp=req"); end
    e = exp_q.pop_front();
    checks++; if (seen !== e) begin failures++; $display("FAIL conflict_second got=%h exp=%h", seen, e); end
    last_fetch = rd_q.pop_front();
    checks++; if (bus.data_stall !== 1'b0 || bus.inst_stall !== 1'b0) begin failures++; $display("FAIL conflict_end_stalls got=d%b/i%b exp=0/0", bus.data_stall, bus.inst_stall); end
    checks++; if (bus.inst_rdata !== last_fetch) begin failures++; $display("FAIL conflict_fetch_rdata got=%h exp=%h", bus.inst_rdata, last_fetch); end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    logic [EW-1:0] e;
    logic [EW-1:0] seen;
    bit to;
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_sel   = 4'b0011;
    bus.data_addr  = 32'h8000_0004;
    bus.data_wdata = 32'h1234_5678;
    exp_q.push_back({1'b1, 4'b0011, 32'h8000_0004, 32'h1234_5678});
    mem_serve(0, 1, 32'hAAAA_5555, seen, to);
    checks++; if (to) begin failures++; $display("FAIL store_timeout got=no_req exp=req"); end
    e = exp_q.pop_front();
    checks++; if (seen !== e) begin failures++; $display("FAIL store_bus got=%h exp=%h", seen, e); end
    checks++; if (bus.data_stall !== 1'b0) begin failures++; $display("FAIL store_stall got=%b exp=0", bus.data_stall); end
    checks++; if (bus.data_rdata !== last_load) begin failures++; $display("FAIL store_rdata_kept got=%h exp=%h", bus.data_rdata, last_load); end
    bus.data_req = 1'b0;
    bus.data_wr  = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [EW-1:0] e;
    logic [EW-1:0] seen;
    bit to;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0020;
    exp_q.push_back({1'b0, 4'hF, 32'hBFC0_0020, 32'h0});
    wait_req(to);
    checks++; if (to) begin failures++; $display("FAIL flush_timeout got=no_req exp=req"); end
    e = exp_q.pop_front();
    checks++; if ({bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== e) begin failures++; $display("FAIL flush_bus got=%h exp=%h", {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata}, e); end
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.mem_addr_ok = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (state !== S_WAIT_I) begin failures++; $display("FAIL flush_still_wait got=%0d exp=%0d", state, S_WAIT_I); end
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'hDEAD_BEEF;
    tick();
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
    checks++; if (bus.inst_rdata !== last_fetch) begin failures++; $display("FAIL flush_rdata_kept got=%h exp=%h", bus.inst_rdata, last_fetch); end
    checks++; if (bus.inst_stall !== 1'b1 || state !== S_IDLE) begin failures++; $display("FAIL flush_not_done got=stall%b/st%0d exp=1/0", bus.inst_stall, state); end
    // the same fetch is still pending and goes out again
    exp_q.push_back({1'b0, 4'hF, 32'hBFC0_0020, 32'h0});
    rd_q.push_back(32'h0000_CAFE);
    mem_serve(0, 1, 32'h0000_CAFE, seen, to);
    checks++; if (to) begin failures++; $display("FAIL refetch_timeout got=no_req exp=req"); end
    e = exp_q.pop_front();
    checks++; if (seen !== e) begin failures++; $display("FAIL refetch_bus got=%h exp=%h", seen, e); end
    last_fetch = rd_q.pop_front();
    checks++; if (bus.inst_rdata !== last_fetch || bus.inst_stall !== 1'b0) begin failures++; $display("FAIL refetch_done got=%h/stall%b exp=%h/0", bus.inst_rdata, bus.inst_stall, last_fetch); end
    bus.inst_req = 1'b0;
    tick();
  endtask

  task automatic test_addr_ok_hold();
    logic [EW-1:0] e;
    bit to;
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_sel   = 4'hF;
    bus.data_addr  = 32'h8000_0040;
    bus.data_wdata = 32'h5A5A_5A5A;
    exp_q.push_back({1'b1, 4'hF, 32'h8000_0040, 32'h5A5A_5A5A});
    wait_req(to);
    checks++; if (to) begin failures++; $display("FAIL hold_timeout got=no_req exp=req"); end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.data_addr  = $urandom;
      bus.data_wdata = $urandom;
      bus.data_sel   = 4'($urandom_range(0, 15));
      bus.data_wr    = 1'($urandom_range(0, 1));
      bus.inst_addr  = $urandom;
      checks++; if (bus.mem_req !== 1'b1 || {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== e) begin failures++; $display("FAIL hold_stable cyc=%0d got=req%b/%h exp=1/%h", i, bus.mem_req, {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata}, e); end
      tick();
    end
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    tick();
    bus.mem_data_ok = 1'b0;
    checks++; if (bus.data_stall !== 1'b0) begin failures++; $display("FAIL hold_done got=%b exp=0", bus.data_stall); end
    bus.data_req = 1'b0;
    bus.data_wr  = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] e;
    logic [EW-1:0] seen;
    logic [AW-1:0] a;
    logic [DW-1:0] r;
    bit to;
    for (int i = 0; i < 4; i++) begin
      a = 32'h8000_1000 + (32'($urandom_range(0, 255)) << 2);
      r = $urandom;
      bus.data_req   = 1'b1;
      bus.data_wr    = 1'b0;
      bus.data_sel   = 4'($urandom_range(0, 15));
      bus.data_addr  = a;
      bus.data_wdata = 32'h0;
      exp_q.push_back({1'b0, 4'hF, a, 32'h0});
      rd_q.push_back(r);
      mem_serve($urandom_range(0, 3), $urandom_range(0, 3), r, seen, to);
      checks++; if (to) begin failures++; $display("FAIL b2b_timeout i=%0d got=no_req exp=req", i); end
      e = exp_q.pop_front();
      checks++; if (seen !== e) begin failures++; $display("FAIL b2b_bus i=%0d got=%h exp=%h", i, seen, e); end
      last_load = rd_q.pop_front();
      checks++; if (bus.data_rdata !== last_load || bus.data_stall !== 1'b0) begin failures++; $display("FAIL b2b_rdata i=%0d got=%h/stall%b exp=%h/0", i, bus.data_rdata, bus.data_stall, last_load); end
      bus.data_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] e;
    bit to;
    bus.data_req  = 1'b1;
    bus.data_wr   = 1'b0;
    bus.data_addr = 32'h8000_0080;
    exp_q.push_back({1'b0, 4'hF, 32'h8000_0080, 32'h0});
    wait_req(to);
    checks++; if (to) begin failures++; $display("FAIL rstmid_timeout got=no_req exp=req"); end
    e = exp_q.pop_front();
    checks++; if ({bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== e) begin failures++; $display("FAIL rstmid_bus got=%h exp=%h", {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_wdata}, e); end
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.mem_addr_ok = 1'b0;
    checks++; if (state !== S_WAIT_D) begin failures++; $display("FAIL rstmid_wait got=%0d exp=%0d", state, S_WAIT_D); end
    bus.inst_req = 1'b1;
    rst = 1'b1;
    tick();
    checks++; if (bus.mem_req !== 1'b0 || state !== S_IDLE) begin failures++; $display("FAIL rstmid_idle got=req%b/st%0d exp=0/0", bus.mem_req, state); end
    checks++; if (bus.data_stall !== bus.data_req || bus.inst_stall !== bus.inst_req) begin failures++; $display("FAIL rstmid_stalls got=d%b/i%b exp=1/1", bus.data_stall, bus.inst_stall); end
    checks++; if (bus.stall_cnt !== 32'd0 || bus.data_rdata !== '0) begin failures++; $display("FAIL rstmid_regs got=%0d/%h exp=0/0", bus.stall_cnt, bus.data_rdata); end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks     = 0;
    failures   = 0;
    last_fetch = '0;
    last_load  = '0;
    rst        = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_alone();
    test_conflict();
    test_store();
    test_flush();
    test_addr_ok_hold();
    test_back_to_back();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
